rx_rsp_scheduler: RTL and testbench

RX_RSP_SCHEDULER -- requirements
Module: rx_rsp_scheduler

---
 rtl/rx_rsp_scheduler_pkg.sv | 27 ++
 rtl/rsp_tag_fifo.sv | 74 +++++++
 rtl/rx_rsp_scheduler.sv | 233 +++++++++++++++++++++++
 tb/tb_rx_rsp_scheduler.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/rx_rsp_scheduler_pkg.sv
// Shared scheduler definitions used by both the RX and TX response schedulers.
// Contents: head-sequencer state encoding, response status codes and the bit
// offsets of the fields inside a 32-bit response frame.
package rx_rsp_scheduler_pkg;

  // Head-of-queue sequencer states
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,  // queue empty
    S_WAIT_RSP = 2'd1,  // head present, data not yet captured
    S_PRESENT  = 2'd2   // frame offered downstream
  } sched_state_e;

  // Response status codes carried in the low byte of the frame
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_TIMEOUT = 8'h01;

  // Frame layout: {op_id, data, sw_idx, status}, one byte each
  localparam int FRM_FIELD_W    = 8;
  localparam int FRM_OPID_LSB   = 24;
  localparam int FRM_DATA_LSB   = 16;
  localparam int FRM_SWIDX_LSB  = 8;
  localparam int FRM_STATUS_LSB = 0;

  // Operation tag width
  localparam int OPID_W = 8;

endpackage

// File: rtl/rsp_tag_fifo.sv
// In-order circular queue of outstanding-read tags.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   push, push_data - write one entry (ignored when full)
//   pop         - remove the head entry (ignored when empty)
//   head_data   - current head entry
//   full, empty - occupancy flags
//   count       - number of stored entries
module rsp_tag_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 11,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (cnt_q == CNT_W'(DEPTH));
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Pointer wrap and occupancy next-state (pointers wrap explicitly so DEPTH need not be a power of two)
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push_s) begin
      if (wr_ptr_q == PTR_W'(DEPTH - 1)) wr_ptr_d = '0;
      else                               wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      if (rd_ptr_q == PTR_W'(DEPTH - 1)) rd_ptr_d = '0;
      else                               rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d = cnt_q + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
  end

  // Pointer, count and storage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (do_push_s) mem_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/rx_rsp_scheduler.sv
// Collects read data returned by a set of switch instances and emits it as
// response frames in the order the reads were issued.
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   issue_*           - operation issued to the switches (reads are queued)
//   issue_rdy         - outstanding queue has room
//   rsp_vld, rsp_data - per-switch read-data strobes and packed data
//   out_vld/out_rdy/out_frame - response frame handshake
//   err_ovf, err_unexp, err_sel - sticky error flags
module rx_rsp_scheduler
  import rx_rsp_scheduler_pkg::*;
#(
  parameter int NUM_SW_INST = 5,
  parameter int W_WIDTH     = 8,
  parameter int FRAME_WIDTH = 32,
  parameter int OUTST_DEPTH = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           issue_vld,
  input  logic [NUM_SW_INST-1:0]         issue_sel,
  input  logic [7:0]                     issue_op_id,
  input  logic                           issue_wr_rd_s,
  output logic                           issue_rdy,
  input  logic [NUM_SW_INST-1:0]         rsp_vld,
  input  logic [NUM_SW_INST*W_WIDTH-1:0] rsp_data,
  output logic                           out_vld,
  input  logic                           out_rdy,
  output logic [FRAME_WIDTH-1:0]         out_frame,
  output logic                           err_ovf,
  output logic                           err_unexp,
  output logic                           err_sel
);

  localparam int SW_W  = (NUM_SW_INST > 1) ? $clog2(NUM_SW_INST) : 1;
  localparam int ENT_W = OPID_W + SW_W;
  localparam int OC_W  = $clog2(OUTST_DEPTH) + 1;
  localparam int CNT_W = $clog2(OUTST_DEPTH + 1);
  localparam int TC_W  = $clog2(TIMEOUT_CYC + 1);

  // True when exactly one bit of the select is set
  function automatic logic onehot_f(input logic [NUM_SW_INST-1:0] v);
    int unsigned n;
    n = 32'd0;
    for (int i = 0; i < NUM_SW_INST; i++) n = n + {31'd0, v[i]};
    return (n == 32'd1);
  endfunction

  // Index of the set bit of a one-hot select
  function automatic logic [SW_W-1:0] idx_f(input logic [NUM_SW_INST-1:0] v);
    logic [SW_W-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      if (v[i]) r = SW_W'(i);
    end
    return r;
  endfunction

  // Assemble a response frame from its fields
  function automatic logic [FRAME_WIDTH-1:0] frame_f(
    input logic [OPID_W-1:0]  op,
    input logic [W_WIDTH-1:0] dat,
    input logic [SW_W-1:0]    sw,
    input logic [7:0]         st
  );
    logic [FRAME_WIDTH-1:0] f;
    f = '0;
    f[FRM_OPID_LSB   +: FRM_FIELD_W] = op;
    f[FRM_DATA_LSB   +: FRM_FIELD_W] = FRM_FIELD_W'(dat);
    f[FRM_SWIDX_LSB  +: FRM_FIELD_W] = FRM_FIELD_W'(sw);
    f[FRM_STATUS_LSB +: FRM_FIELD_W] = st;
    return f;
  endfunction

  sched_state_e            state_q, state_d;
  logic                    out_vld_q, out_vld_d;
  logic [FRAME_WIDTH-1:0]  frame_q, frame_d;
  logic [TC_W-1:0]         tmo_q, tmo_d;
  logic [OC_W-1:0]         outst_q [NUM_SW_INST];
  logic [OC_W-1:0]         outst_d [NUM_SW_INST];
  logic [W_WIDTH-1:0]      cap_q   [NUM_SW_INST];
  logic [W_WIDTH-1:0]      cap_d   [NUM_SW_INST];
  logic [NUM_SW_INST-1:0]  pend_q, pend_d;
  logic                    err_ovf_q, err_unexp_q, err_sel_q;

  logic                    full_s, empty_s;
  logic [CNT_W-1:0]        cnt_s;
  logic [ENT_W-1:0]        head_s;
  logic [OPID_W-1:0]       head_op_s;
  logic [SW_W-1:0]         head_sw_s;
  logic                    head_pend_s;
  logic [W_WIDTH-1:0]      head_cap_s;
  logic                    rd_acc_s, sel_ok_s, push_s, pop_s;
  logic [SW_W-1:0]         push_idx_s;
  logic [NUM_SW_INST-1:0]  sw_inc_s, sw_dec_s, outst_zero_s, capture_s;

  // Full blocks new issues even if the head pops this cycle
  assign issue_rdy  = ~full_s;
  assign rd_acc_s   = issue_vld & issue_rdy & ~issue_wr_rd_s;
  assign sel_ok_s   = onehot_f(issue_sel);
  assign push_s     = rd_acc_s & sel_ok_s;
  assign push_idx_s = idx_f(issue_sel);
  assign pop_s      = out_vld_q & out_rdy;
  assign head_op_s  = head_s[ENT_W-1 -: OPID_W];
  assign head_sw_s  = head_s[SW_W-1:0];

  assign out_vld    = out_vld_q;
  assign out_frame  = frame_q;
  assign err_ovf    = err_ovf_q;
  assign err_unexp  = err_unexp_q;
  assign err_sel    = err_sel_q;

  rsp_tag_fifo #(
    .DEPTH (OUTST_DEPTH),
    .WIDTH (ENT_W)
  ) u_tag_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_s),
    .push_data ({issue_op_id, push_idx_s}),
    .pop       (pop_s),
    .head_data (head_s),
    .full      (full_s),
    .empty     (empty_s),
    .count     (cnt_s)
  );

  // Per-switch bookkeeping: outstanding counts, capture registers, pending flags
  always_comb begin
    head_pend_s = 1'b0;
    head_cap_s  = '0;
    for (int i = 0; i < NUM_SW_INST; i++) begin
      sw_inc_s[i]     = push_s & (push_idx_s == SW_W'(i));
      sw_dec_s[i]     = pop_s & (head_sw_s == SW_W'(i));
      outst_zero_s[i] = (outst_q[i] == '0);
      capture_s[i]    = rsp_vld[i] & ~outst_zero_s[i] & ~pend_q[i];
      // inc and dec on the same switch cancel out
      outst_d[i]      = outst_q[i] + OC_W'(sw_inc_s[i]) - OC_W'(sw_dec_s[i]);
      // Popping the head frees its slot even if new data strobes in that cycle
      if (sw_dec_s[i])       pend_d[i] = 1'b0;
      else if (capture_s[i]) pend_d[i] = 1'b1;
      else                   pend_d[i] = pend_q[i];
      if (capture_s[i]) cap_d[i] = rsp_data[i*W_WIDTH +: W_WIDTH];
      else              cap_d[i] = cap_q[i];
      if (head_sw_s == SW_W'(i)) begin
        head_pend_s = pend_q[i];
        head_cap_s  = cap_q[i];
      end else begin
        head_pend_s = head_pend_s;
      end
    end
  end

  // Head sequencer next-state and frame assembly
  always_comb begin
    state_d   = state_q;
    out_vld_d = out_vld_q;
    frame_d   = frame_q;
    tmo_d     = tmo_q;
    case (state_q)
      S_IDLE: begin
        tmo_d = '0;
        if (!empty_s) state_d = S_WAIT_RSP;
        else          state_d = S_IDLE;
      end
      S_WAIT_RSP: begin
        if (head_pend_s) begin
          state_d   = S_PRESENT;
          out_vld_d = 1'b1;
          frame_d   = frame_f(head_op_s, head_cap_s, head_sw_s, ST_OK);
          tmo_d     = '0;
        end else if (tmo_q == TC_W'(TIMEOUT_CYC - 1)) begin
          // this cycle is the last allowed wait cycle
          state_d   = S_PRESENT;
          out_vld_d = 1'b1;
          frame_d   = frame_f(head_op_s, '0, head_sw_s, ST_TIMEOUT);
          tmo_d     = '0;
        end else begin
          tmo_d     = tmo_q + TC_W'(1);
        end
      end
      S_PRESENT: begin
        tmo_d = '0;
        if (out_rdy) begin
          out_vld_d = 1'b0;
          // entries left behind the popped head (a same-cycle push also counts)
          if ((cnt_s > CNT_W'(1)) || push_s) state_d = S_WAIT_RSP;
          else                               state_d = S_IDLE;
        end else begin
          out_vld_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        out_vld_d = 1'b0;
        tmo_d     = '0;
      end
    endcase
  end

  // State, frame, per-switch and sticky error registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      out_vld_q   <= 1'b0;
      frame_q     <= '0;
      tmo_q       <= '0;
      pend_q      <= '0;
      err_ovf_q   <= 1'b0;
      err_unexp_q <= 1'b0;
      err_sel_q   <= 1'b0;
      for (int i = 0; i < NUM_SW_INST; i++) begin
        outst_q[i] <= '0;
        cap_q[i]   <= '0;
      end
    end else begin
      state_q     <= state_d;
      out_vld_q   <= out_vld_d;
      frame_q     <= frame_d;
      tmo_q       <= tmo_d;
      pend_q      <= pend_d;
      err_ovf_q   <= err_ovf_q   | (|(rsp_vld & ~outst_zero_s & pend_q));
      err_unexp_q <= err_unexp_q | (|(rsp_vld & outst_zero_s));
      err_sel_q   <= err_sel_q   | (rd_acc_s & ~sel_ok_s);
      for (int i = 0; i < NUM_SW_INST; i++) begin
        outst_q[i] <= outst_d[i];
        cap_q[i]   <= cap_d[i];
      end
    end
  end

endmodule

// File: tb/tb_rx_rsp_scheduler.sv
// Directed self-checking bench for rx_rsp_scheduler.
module tb_rx_rsp_scheduler;

  localparam int NSW = 5;
  localparam int W   = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issue_vld;
  logic [NSW-1:0]    issue_sel;
  logic [7:0]        issue_op_id;
  logic              issue_wr_rd_s;
  logic              issue_rdy;
  logic [NSW-1:0]    rsp_vld;
  logic [NSW*W-1:0]  rsp_data;
  logic              out_vld;
  logic              out_rdy;
  logic [31:0]       out_frame;
  logic              err_ovf, err_unexp, err_sel;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rx_rsp_scheduler #(
    .NUM_SW_INST (NSW),
    .W_WIDTH     (W),
    .FRAME_WIDTH (32),
    .OUTST_DEPTH (4),
    .TIMEOUT_CYC (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .issue_vld     (issue_vld),
    .issue_sel     (issue_sel),
    .issue_op_id   (issue_op_id),
    .issue_wr_rd_s (issue_wr_rd_s),
    .issue_rdy     (issue_rdy),
    .rsp_vld       (rsp_vld),
    .rsp_data      (rsp_data),
    .out_vld       (out_vld),
    .out_rdy       (out_rdy),
    .out_frame     (out_frame),
    .err_ovf       (err_ovf),
    .err_unexp     (err_unexp),
    .err_sel       (err_sel)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [7:0] op, input logic [NSW-1:0] sel, input logic wr);
    issue_vld = 1'b1; issue_sel = sel; issue_op_id = op; issue_wr_rd_s = wr;
    tick();
    issue_vld = 1'b0; issue_sel = '0; issue_op_id = 8'h00; issue_wr_rd_s = 1'b0;
  endtask

  task automatic rsp(input int idx, input logic [7:0] d);
    rsp_vld = '0; rsp_data = '0;
    rsp_vld[idx] = 1'b1;
    rsp_data[idx*W +: W] = d;
    tick();
    rsp_vld = '0; rsp_data = '0;
  endtask

  task automatic wait_vld(input int max, output bit seen, output int n);
    n = 0;
    while (!out_vld && n < max) begin
      tick();
      n++;
    end
    seen = out_vld;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; issue_vld = 1'b0; issue_sel = '0; issue_op_id = 8'h00;
    issue_wr_rd_s = 1'b0; rsp_vld = '0; rsp_data = '0; out_rdy = 1'b0;
    repeat (2) tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL reset_out_vld: got %b expected 0", out_vld); end
    checks++; if (out_frame !== 32'h0) begin errors++; $display("FAIL reset_frame: got %h expected 00000000", out_frame); end
    checks++; if ({err_ovf, err_unexp, err_sel} !== 3'b000) begin errors++; $display("FAIL reset_err: got %b expected 000", {err_ovf, err_unexp, err_sel}); end
    rst_n = 1'b1;
    tick();
    checks++; if (issue_rdy !== 1'b1) begin errors++; $display("FAIL reset_issue_rdy: got %b expected 1", issue_rdy); end
  endtask

  task automatic test_basic();
    out_rdy = 1'b1;
    issue(8'h11, 5'b00100, 1'b0);
    tick(); tick();
    rsp(2, 8'hA5);
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL basic_capture_edge: got %b expected 0", out_vld); end
    tick();
    checks++; if (out_vld !== 1'b1) begin errors++; $display("FAIL basic_out_vld: got %b expected 1", out_vld); end
    checks++; if (out_frame !== 32'h11A50200) begin errors++; $display("FAIL basic_frame: got %h expected 11a50200", out_frame); end
    tick();
    checks++; if (out_vld !== 1'b0) begin errors++; $display("FAIL basic_pop: got %b expected 0", out_vld); end
  endtask

  task automatic test_order();
    bit seen; int n;
    out_rdy = 1'b1;
    issue(8'h01, 5'b00001, 1'b0);
    issue(8'h02, 5'b00010, 1'b0);
    rsp(1, 8'h22);
    rsp(0, 8'h33);
    wait_vld(10, seen, n);
    checks++; if (!seen || out_frame !== 32'h01330000) begin errors++; $display("FAIL order_first: got vld=%b %h expected 01330000", seen, out_frame); end
    tick();
    wait_vld(10, seen, n);
    checks++; if (!seen || out_frame !== 32'h02220100) begin errors++; $display("FAIL order_second: got vld=%b %h expected 02220100", seen, out_frame); end
    tick();
  endtask

  task automatic test_full();
    bit seen, saw; int n;
    logic [7:0] d;
    logic [31:0] exp;
    out_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      issue(8'h41 + 8'(i), 5'(1 << i), 1'b0);
    end
    checks++; if (issue_rdy !== 1'b0) begin errors++; $display("FAIL full_issue_rdy: got %b expected 0", issue_rdy); end
    issue(8'h45, 5'b10000, 1'b0);
    rsp(0, 8'h5A);
    wait_vld(10, seen, n);
    checks++; if (!seen || out_frame !== 32'h415A0000) begin errors++; $display("FAIL full_head_frame: got vld=%b %h expected 415a0000", seen, out_frame); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_vld !== 1'b1 || out_frame !== 32'h415A0000) begin errors++; $display("FAIL full_hold: got vld=%b %h expected vld=1 415a0000", out_vld, out_frame); end
    end
    out_rdy = 1'b1;
    tick();
    checks++; if (issue_rdy !== 1'b1) begin errors++; $display("FAIL full_rdy_after_pop: got %b expected 1", issue_rdy); end
    for (int i = 1; i < 4; i++) begin
      d = 8'h60 + 8'(i);
      rsp(i, d);
      wait_vld(10, seen, n);
      exp = {8'h41 + 8'(i), d, 8'(i), 8'h00};
      checks++; if (!seen || out_frame !== exp) begin errors++; $display("FAIL full_drain: got vld=%b %h expected %h", seen, out_frame, exp); end
      tick();
    end
    saw = 1'b0;
    repeat (20) begin tick(); if (out_vld) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL full_fifth_rejected: got frame=%b expected none", saw); end
  endtask

  task automatic test_timeout();
    bit seen; int n;
    out_rdy = 1'b1;
    issue(8'h33, 5'b10000, 1'b0);
    wait_vld(40, seen, n);
    // one cycle to leave IDLE plus sixteen waiting cycles
    checks++; if (!seen || n != 17) begin errors++; $display("FAIL timeout_latency: got vld=%b cycles=%0d expected 17", seen, n); end
    checks++; if (out_frame !== 32'h33000401) begin errors++; $display("FAIL timeout_frame: got %h expected 33000401", out_frame); end
    tick();
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL timeout_unexp_pre: got %b expected 0", err_unexp); end
    rsp(4, 8'h99);
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL timeout_unexp: got %b expected 1", err_unexp); end
  endtask

  task automatic test_errors();
    bit seen, saw; int n;
    out_rdy = 1'b0;
    issue(8'h55, 5'b00010, 1'b0);
    rsp(1, 8'hC3);
    checks++; if (err_ovf !== 1'b0) begin errors++; $display("FAIL err_ovf_pre: got %b expected 0", err_ovf); end
    rsp(1, 8'h3C);
    checks++; if (err_ovf !== 1'b1) begin errors++; $display("FAIL err_ovf: got %b expected 1", err_ovf); end
    wait_vld(10, seen, n);
    checks++; if (!seen || out_frame !== 32'h55C30100) begin errors++; $display("FAIL err_ovf_keep_first: got vld=%b %h expected 55c30100", seen, out_frame); end
    out_rdy = 1'b1;
    tick();
    issue(8'h66, 5'b00001, 1'b1);
    saw = 1'b0;
    repeat (20) begin tick(); if (out_vld) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL write_no_frame: got frame=%b expected none", saw); end
    checks++; if (err_sel !== 1'b0) begin errors++; $display("FAIL err_sel_pre: got %b expected 0", err_sel); end
    issue(8'h77, 5'b00011, 1'b0);
    checks++; if (err_sel !== 1'b1) begin errors++; $display("FAIL err_sel: got %b expected 1", err_sel); end
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL err_unexp_sticky: got %b expected 1", err_unexp); end
  endtask

  task automatic test_reset_mid();
    bit seen, saw; int n;
    out_rdy = 1'b0;
    issue(8'h71, 5'b00001, 1'b0);
    issue(8'h72, 5'b00010, 1'b0);
    issue(8'h73, 5'b00100, 1'b0);
    rsp(0, 8'h11);
    wait_vld(10, seen, n);
    checks++; if (!seen || out_frame !== 32'h71110000) begin errors++; $display("FAIL rstmid_present: got vld=%b %h expected 71110000", seen, out_frame); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_vld !== 1'b0 || out_frame !== 32'h0) begin errors++; $display("FAIL rstmid_outputs: got vld=%b %h expected 0 00000000", out_vld, out_frame); end
    checks++; if ({err_ovf, err_unexp, err_sel} !== 3'b000) begin errors++; $display("FAIL rstmid_err: got %b expected 000", {err_ovf, err_unexp, err_sel}); end
    tick();
    rst_n = 1'b1;
    tick();
    checks++; if (issue_rdy !== 1'b1) begin errors++; $display("FAIL rstmid_issue_rdy: got %b expected 1", issue_rdy); end
    out_rdy = 1'b1;
    rsp(1, 8'h42);
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL rstmid_outst_cleared: got %b expected 1", err_unexp); end
    saw = 1'b0;
    repeat (25) begin tick(); if (out_vld) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL rstmid_stale_frame: got frame=%b expected none", saw); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_order();
    test_full();
    test_timeout();
    test_errors();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
